// File: rtl/csr_pkg.sv
// Shared encodings for the CSR command issuer and the CSR unit it drives.
// Op codes, FSM states, exception codes and architectural CSR numbers.
package csr_pkg;

    localparam logic [1:0] OP_RD   = 2'd0;
    localparam logic [1:0] OP_WR   = 2'd1;
    localparam logic [1:0] OP_XCHG = 2'd2;
    localparam logic [1:0] OP_ERTN = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_COMMIT = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;

endpackage

// File: rtl/csr_cmd_issuer.sv
// Sequences one retired CSR-class instruction through the CSR unit:
// read, read-modify-write with register writeback, or exception/ertn flush.
module csr_cmd_issuer
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [13:0] in_csr_num,
    input  logic [31:0] in_rd_val,
    input  logic [31:0] in_rj_val,
    input  logic [4:0]  in_dest,
    input  logic [31:0] in_pc,
    input  logic        in_ex,
    input  logic [5:0]  in_ecode,
    input  logic [8:0]  in_esubcode,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] er_entry,
    output logic        csr_re,
    output logic [13:0] csr_rnum,
    input  logic [31:0] csr_rdata,
    output logic        csr_we,
    output logic [13:0] csr_wnum,
    output logic [31:0] csr_wdata,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic        ertn_flush,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flush_valid,
    output logic [31:0] flush_target
);

    state_t      state_q, state_d;
    logic [1:0]  op_q;
    logic [13:0] num_q;
    logic [31:0] rd_val_q, rj_val_q, pc_q, old_q;
    logic [4:0]  dest_q;
    logic [5:0]  ecode_q;
    logic [8:0]  esub_q;
    logic        ertn_q;
    logic        accept;
    logic        to_flush;

    assign in_ready = (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;
    // Interrupts and exceptions outrank ertn; all three bypass the CSR read.
    assign to_flush = has_int || in_ex || (in_op == OP_ERTN);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            op_q     <= OP_RD;
            num_q    <= '0;
            rd_val_q <= '0;
            rj_val_q <= '0;
            pc_q     <= '0;
            old_q    <= '0;
            dest_q   <= '0;
            ecode_q  <= '0;
            esub_q   <= '0;
            ertn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= in_op;
                num_q    <= in_csr_num;
                rd_val_q <= in_rd_val;
                rj_val_q <= in_rj_val;
                pc_q     <= in_pc;
                dest_q   <= in_dest;
                ecode_q  <= has_int ? ECODE_INT : in_ecode;
                esub_q   <= has_int ? 9'd0 : in_esubcode;
                ertn_q   <= !has_int && !in_ex && (in_op == OP_ERTN);
            end
            if (state_q == S_READ)
                old_q <= csr_rdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        csr_re       = 1'b0;
        csr_rnum     = '0;
        csr_we       = 1'b0;
        csr_wnum     = '0;
        csr_wdata    = '0;
        wb_ex        = 1'b0;
        wb_ecode     = '0;
        wb_esubcode  = '0;
        wb_pc        = '0;
        ertn_flush   = 1'b0;
        rf_we        = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        flush_valid  = 1'b0;
        flush_target = '0;
        case (state_q)
            S_IDLE: begin
                if (accept)
                    state_d = to_flush ? S_FLUSH : S_READ;
            end
            S_READ: begin
                csr_re   = 1'b1;
                csr_rnum = num_q;
                state_d  = S_COMMIT;
            end
            S_COMMIT: begin
                if (op_q == OP_WR || op_q == OP_XCHG) begin
                    csr_we    = 1'b1;
                    csr_wnum  = num_q;
                    csr_wdata = (op_q == OP_XCHG) ? ((rd_val_q & rj_val_q) | (old_q & ~rj_val_q))
                                                  : rd_val_q;
                end
                if (dest_q != 5'd0) begin
                    rf_we    = 1'b1;
                    rf_waddr = dest_q;
                    rf_wdata = old_q;
                end
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                flush_valid = 1'b1;
                if (ertn_q) begin
                    ertn_flush   = 1'b1;
                    flush_target = er_entry;
                end else begin
                    wb_ex        = 1'b1;
                    wb_ecode     = ecode_q;
                    wb_esubcode  = esub_q;
                    wb_pc        = pc_q;
                    flush_target = ex_entry;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_cmd_issuer.sv
// Directed-vector bench for csr_cmd_issuer: stimulus pushes expected active-cycle
// snapshots into a queue, a negedge monitor pops and compares them.
module tb_csr_cmd_issuer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = '0;
    logic [13:0] in_csr_num = '0;
    logic [31:0] in_rd_val = '0;
    logic [31:0] in_rj_val = '0;
    logic [4:0]  in_dest = '0;
    logic [31:0] in_pc = '0;
    logic        in_ex = 1'b0;
    logic [5:0]  in_ecode = '0;
    logic [8:0]  in_esubcode = '0;
    logic        has_int = 1'b0;
    logic [31:0] ex_entry = 32'h1C00_8000;
    logic [31:0] er_entry = 32'h1C00_0200;
    logic        csr_re;
    logic [13:0] csr_rnum;
    logic [31:0] csr_rdata = '0;
    logic        csr_we;
    logic [13:0] csr_wnum;
    logic [31:0] csr_wdata;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        ertn_flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flush_valid;
    logic [31:0] flush_target;

    csr_cmd_issuer dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_csr_num(in_csr_num), .in_rd_val(in_rd_val), .in_rj_val(in_rj_val),
        .in_dest(in_dest), .in_pc(in_pc), .in_ex(in_ex), .in_ecode(in_ecode),
        .in_esubcode(in_esubcode), .has_int(has_int),
        .ex_entry(ex_entry), .er_entry(er_entry),
        .csr_re(csr_re), .csr_rnum(csr_rnum), .csr_rdata(csr_rdata),
        .csr_we(csr_we), .csr_wnum(csr_wnum), .csr_wdata(csr_wdata),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc),
        .ertn_flush(ertn_flush), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flush_valid(flush_valid), .flush_target(flush_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        csr_re;
        logic [13:0] csr_rnum;
        logic        csr_we;
        logic [13:0] csr_wnum;
        logic [31:0] csr_wdata;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        wb_ex;
        logic [5:0]  wb_ecode;
        logic [8:0]  wb_esubcode;
        logic [31:0] wb_pc;
        logic        ertn_flush;
        logic        flush_valid;
        logic [31:0] flush_target;
    } snap_t;

    snap_t act;
    assign act = {csr_re, csr_rnum, csr_we, csr_wnum, csr_wdata, rf_we, rf_waddr, rf_wdata,
                  wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush, flush_valid, flush_target};

    snap_t exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic snap_t e_read(input logic [13:0] num);
        snap_t s = '0;
        s.csr_re = 1'b1; s.csr_rnum = num;
        return s;
    endfunction

    function automatic snap_t e_commit(input logic we, input logic [13:0] wnum, input logic [31:0] wdata,
                                       input logic rfwe, input logic [4:0] waddr, input logic [31:0] rwdata);
        snap_t s = '0;
        s.csr_we = we; s.csr_wnum = wnum; s.csr_wdata = wdata;
        s.rf_we = rfwe; s.rf_waddr = waddr; s.rf_wdata = rwdata;
        return s;
    endfunction

    function automatic snap_t e_ex(input logic [5:0] ec, input logic [8:0] esc,
                                   input logic [31:0] pc, input logic [31:0] tgt);
        snap_t s = '0;
        s.wb_ex = 1'b1; s.wb_ecode = ec; s.wb_esubcode = esc; s.wb_pc = pc;
        s.flush_valid = 1'b1; s.flush_target = tgt;
        return s;
    endfunction

    function automatic snap_t e_ertn(input logic [31:0] tgt);
        snap_t s = '0;
        s.ertn_flush = 1'b1; s.flush_valid = 1'b1; s.flush_target = tgt;
        return s;
    endfunction

    // Monitor: any cycle with an active output must match the head of the queue.
    always @(negedge clk) begin
        if (resetn && (act != '0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output act=%h required=none", act);
            end else begin
                snap_t e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL monitor act=%h required=%h", act, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%h required=%h", name, a, e);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [13:0] num, input logic [31:0] rd,
                         input logic [31:0] rj, input logic [4:0] dest, input logic [31:0] pc,
                         input logic ex, input logic [5:0] ec, input logic [8:0] esc, input logic hint);
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = op; in_csr_num = num; in_rd_val = rd; in_rj_val = rj;
        in_dest = dest; in_pc = pc; in_ex = ex; in_ecode = ec; in_esubcode = esc; has_int = hint;
        @(posedge clk); #1;
        in_valid = 1'b0; in_ex = 1'b0; has_int = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_outputs", 64'(act != '0), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        #22 resetn = 1'b1;

        // csrwr SAVE0
        csr_rdata = 32'hAAAA_0000;
        exp_q.push_back(e_read(14'h30));
        exp_q.push_back(e_commit(1'b1, 14'h30, 32'h1234_5678, 1'b1, 5'd5, 32'hAAAA_0000));
        issue(2'd1, 14'h30, 32'h1234_5678, 32'h0, 5'd5, 32'h1C00_0000, 1'b0, 6'h0, 9'h0, 1'b0);
        chk("wr_ready_T1", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("wr_ready_T2", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("wr_ready_T3", 64'(in_ready), 64'd1);

        // csrxchg, dest=0 suppresses the register write
        csr_rdata = 32'hFFFF_0000;
        exp_q.push_back(e_read(14'h31));
        exp_q.push_back(e_commit(1'b1, 14'h31, 32'hFF00_00FF, 1'b0, 5'd0, 32'h0));
        issue(2'd2, 14'h31, 32'h0000_FFFF, 32'h00FF_00FF, 5'd0, 32'h1C00_0004, 1'b0, 6'h0, 9'h0, 1'b0);
        repeat (2) @(posedge clk);

        // csrrd ESTAT
        csr_rdata = 32'h0000_00B3;
        exp_q.push_back(e_read(14'h5));
        exp_q.push_back(e_commit(1'b0, 14'h0, 32'h0, 1'b1, 5'd7, 32'h0000_00B3));
        issue(2'd0, 14'h5, 32'hDEAD_BEEF, 32'h0, 5'd7, 32'h1C00_0008, 1'b0, 6'h0, 9'h0, 1'b0);
        repeat (2) @(posedge clk);

        // has_int rising mid-sequence is ignored
        csr_rdata = 32'h1111_1111;
        exp_q.push_back(e_read(14'h32));
        exp_q.push_back(e_commit(1'b1, 14'h32, 32'hCAFE_F00D, 1'b1, 5'd3, 32'h1111_1111));
        issue(2'd1, 14'h32, 32'hCAFE_F00D, 32'h0, 5'd3, 32'h1C00_000C, 1'b0, 6'h0, 9'h0, 1'b0);
        has_int = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        has_int = 1'b0;

        // syscall exception
        exp_q.push_back(e_ex(6'h0B, 9'h0, 32'h1C00_0100, 32'h1C00_8000));
        issue(2'd0, 14'h5, 32'h0, 32'h0, 5'd4, 32'h1C00_0100, 1'b1, 6'h0B, 9'h0, 1'b0);
        chk("ex_ready_T1", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("ex_ready_T2", 64'(in_ready), 64'd1);

        // interrupt outranks a carried exception
        exp_q.push_back(e_ex(6'h00, 9'h0, 32'h1C00_0104, 32'h1C00_8000));
        issue(2'd1, 14'h30, 32'h0, 32'h0, 5'd4, 32'h1C00_0104, 1'b1, 6'h08, 9'h3, 1'b1);
        @(posedge clk);

        // ertn
        exp_q.push_back(e_ertn(32'h1C00_0200));
        issue(2'd3, 14'h0, 32'h0, 32'h0, 5'd0, 32'h1C00_0108, 1'b0, 6'h0, 9'h0, 1'b0);
        @(posedge clk); #1;
        chk("ertn_ready_T2", 64'(in_ready), 64'd1);

        // reset during READ aborts the write entirely
        csr_rdata = 32'h5555_5555;
        issue(2'd1, 14'h33, 32'h7777_7777, 32'h0, 5'd9, 32'h1C00_010C, 1'b0, 6'h0, 9'h0, 1'b0);
        chk("pre_reset_re", 64'(csr_re), 64'd1);
        #1 resetn = 1'b0;
        #1;
        chk("midreset_outputs", 64'(act != '0), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); @(posedge clk); #3;
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout act=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
